sub_nibble_seq: RTL

- Sequenced wide 2's complement subtractor that reuses one 4-bit subtractor slice with carry-in.
- Computes res = a - b on 4*NIBBLES-bit operands, one nibble per clock, LSB nibble first, chaining the carry between nibbles.
- Start/busy/done handshake.
- Sits between a requester (CPU/ALU sequencer) and the shared 4-bit slice, replacing a wide combinational subtractor where area matters.

---
 rtl/sub_seq_pkg.sv | 18 +
 rtl/sub_nibble_seq_if.sv | 26 ++
 rtl/sub_2s_comp_cin.sv | 19 +
 rtl/sub_nibble_seq.sv | 122 ++++++++++++
 4 files changed

// File: rtl/sub_seq_pkg.sv
// Shared constants, FSM encoding and helpers for sub_nibble_seq.
// Optional signed overflow flag: define SUB_NIBBLE_SEQ_OVF_EN.
package sub_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sub_nibble_seq_if.sv
// Request/result bundle between a requester and sub_nibble_seq.
// Optional signed overflow flag: define SUB_NIBBLE_SEQ_OVF_EN.
interface sub_nibble_seq_if #(
  parameter int W = 16
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b,
    input  busy, done, res, cout, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, res, cout, ovf
  );

endinterface

// File: rtl/sub_2s_comp_cin.sv
// Combinational 4-bit slice: {cout, d4} = a4 + ~b4 + cin.
// Optional signed overflow flag: define SUB_NIBBLE_SEQ_OVF_EN.
module sub_2s_comp_cin
  import sub_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] d4,
  output logic                cout
);

  always_comb begin
    {cout, d4} = {1'b0, a4}
               + {1'b0, ~b4}
               + {{NIBBLE_W{1'b0}}, cin};
  end

endmodule

// File: rtl/sub_nibble_seq.sv
// Sequenced wide subtractor: one nibble per clock through a shared slice.
// Optional signed overflow flag: define SUB_NIBBLE_SEQ_OVF_EN.
module sub_nibble_seq
  import sub_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sub_nibble_seq_if.slave bus
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = (clog2(NIBBLES) < 1) ? 1
                    : clog2(NIBBLES);

  logic [1:0]          state;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic [W-1:0]        acc;
  logic [W-1:0]        res_r;
  logic [IW-1:0]       idx;
  logic                carry;
  logic                done_r;
  logic                cout_r;
  logic                ovf_r;

  logic [W-1:0]        a_sh;
  logic [W-1:0]        b_sh;
  logic [NIBBLE_W-1:0] a_n;
  logic [NIBBLE_W-1:0] b_n;
  logic [NIBBLE_W-1:0] d_n;
  logic                c_n;
  logic [W-1:0]        acc_nx;
  logic                last;
  logic                ovf_nx;

  always_comb begin
    a_sh   = a_r >> {idx, 2'b00};
    b_sh   = b_r >> {idx, 2'b00};
    a_n    = a_sh[NIBBLE_W-1:0];
    b_n    = b_sh[NIBBLE_W-1:0];
    acc_nx = acc | (W'(d_n) << {idx, 2'b00});
    last   = (idx == IW'(NIBBLES - 1));
  end

  sub_2s_comp_cin u_slice (
    .a4   (a_n),
    .b4   (b_n),
    .cin  (carry),
    .d4   (d_n),
    .cout (c_n)
  );

`ifdef SUB_NIBBLE_SEQ_OVF_EN
  logic [NIBBLE_W-1:0] low3;

  // Carry into the slice MSB: only meaningful on the top nibble
  always_comb begin
    low3   = {1'b0, a_n[2:0]}
           + {1'b0, ~b_n[2:0]}
           + {3'b000, carry};
    ovf_nx = low3[3] ^ c_n;
  end
`else
  assign ovf_nx = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      res_r  <= '0;
      idx    <= '0;
      carry  <= 1'b1;
      done_r <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (1'b1)
        (state == IDLE),
        (state == DONE): begin
          if (bus.start) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            acc   <= '0;
            idx   <= '0;
            carry <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        (state == RUN): begin
          acc   <= acc_nx;
          carry <= c_n;
          if (last) begin
            idx    <= '0;
            res_r  <= acc_nx;
            cout_r <= c_n;
            ovf_r  <= ovf_nx;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_r;
  assign bus.res  = res_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule
